// File: rtl/countdown_timer_if.sv
// Board-side I/O of the countdown timer: preset switches, six 7-segment digits, status LEDs.
interface countdown_timer_if;
  logic [5:0] SW;
  logic [7:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [9:0] LEDR;

  modport master (output SW, input HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR);
  modport slave  (input SW, output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, LEDR);
endinterface

// File: rtl/countdown_timer.sv
// MM:SS.cc countdown timer with a debounced start/pause/clear button,
// registered active-low 7-segment display and status LEDs.
//
// state | meaning
// IDLE  | digits follow the switch preset, waiting for a press
// RUN   | prescaler counting, digits drop one hundredth per tick
// PAUSE | digits and prescaler frozen
// DONE  | reached zero, display and LEDs blink until a press
module countdown_timer #(
  parameter int unsigned CLKS_PER_TICK = 500000,
  parameter int unsigned DEBOUNCE_CLKS = 1000000,
  parameter int unsigned BLINK_CLKS    = 12500000
) (
  input  logic             CLOCK_50,
  input  logic [1:0]       KEY,
  countdown_timer_if.slave io
);

  localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int DW = $clog2(DEBOUNCE_CLKS + 1);
  localparam int BW = $clog2(BLINK_CLKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  logic            rst_n;
  logic            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]      vld_q, vld_d;
  logic            stable_q, stable_d, armed_q, armed_d;
  logic [DW-1:0]   db_cnt_q, db_cnt_d;
  logic            press;
  state_t          state_q, state_d;
  logic [5:0][3:0] dig_q, dig_d, dig_dec, preset;
  logic            borrow;
  logic [PW-1:0]   presc_q, presc_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            phase_q, phase_d;
  logic [5:0][7:0] hex_q, hex_d;
  logic [9:0]      ledr_q, ledr_d;

  assign rst_n = KEY[0];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // vld tracks when sync2 holds a real sample rather than its reset value;
  // the button is only armed once it has been seen released after reset.
  always_comb begin
    sync1_d  = KEY[1];
    sync2_d  = sync1_q;
    vld_d    = {vld_q[0], 1'b1};
    stable_d = stable_q;
    db_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CLKS - 1)) stable_d = sync2_q;
      else db_cnt_d = db_cnt_q + DW'(1);
    end
    armed_d = armed_q | (vld_q[1] & sync2_q & stable_q);
  end

  assign press = armed_q & stable_q & ~stable_d;

  always_comb begin
    preset    = '0;
    preset[5] = {2'b00, io.SW[5:4]};
    preset[4] = (io.SW[3:0] > 4'd9) ? 4'd9 : io.SW[3:0];
  end

  // Tens of minutes never wraps: a borrow out of it would only occur at zero.
  always_comb begin
    dig_dec = dig_q;
    borrow  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (borrow) begin
        if (dig_q[i] != 4'd0) begin
          dig_dec[i] = dig_q[i] - 4'd1;
          borrow     = 1'b0;
        end else if (i == 3) begin
          dig_dec[i] = 4'd5;
        end else if (i < 5) begin
          dig_dec[i] = 4'd9;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      vld_q    <= '0;
      stable_q <= 1'b1;
      armed_q  <= 1'b0;
      db_cnt_q <= '0;
      state_q  <= S_IDLE;
      dig_q    <= '0;
      presc_q  <= '0;
      blink_q  <= '0;
      phase_q  <= 1'b0;
      hex_q    <= '1;
      ledr_q   <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      vld_q    <= vld_d;
      stable_q <= stable_d;
      armed_q  <= armed_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      dig_q    <= dig_d;
      presc_q  <= presc_d;
      blink_q  <= blink_d;
      phase_q  <= phase_d;
      hex_q    <= hex_d;
      ledr_q   <= ledr_d;
    end
  end

  // A press wins over a coincident tick, so the prescaler simply holds on pause.
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    presc_d = presc_q;
    blink_d = '0;
    phase_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        dig_d   = preset;
        presc_d = '0;
        if (press) begin
          if (preset == '0) begin
            state_d = S_DONE;
            phase_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (press) begin
          state_d = S_PAUSE;
        end else if (presc_q == PW'(CLKS_PER_TICK - 1)) begin
          presc_d = '0;
          dig_d   = dig_dec;
          if (dig_dec == '0) begin
            state_d = S_DONE;
            phase_d = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      S_PAUSE: begin
        if (press) state_d = S_RUN;
      end
      S_DONE: begin
        dig_d = '0;
        if (press) begin
          state_d = S_IDLE;
        end else if (blink_q == BW'(BLINK_CLKS - 1)) begin
          phase_d = ~phase_q;
        end else begin
          blink_d = blink_q + BW'(1);
          phase_d = phase_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hex_d  = '1;
    ledr_d = '0;
    if (!(state_q == S_DONE && !phase_q)) begin
      for (int i = 0; i < 6; i++) begin
        hex_d[i] = {((i == 2) || (i == 4)) ? 1'b0 : 1'b1, seg7(dig_q[i])};
      end
    end
    case (state_q)
      S_RUN:   ledr_d = 10'h001;
      S_PAUSE: ledr_d = 10'h002;
      S_DONE:  ledr_d = phase_q ? 10'h3FF : 10'h000;
      default: ledr_d = 10'h000;
    endcase
  end

  assign io.HEX0 = hex_q[0];
  assign io.HEX1 = hex_q[1];
  assign io.HEX2 = hex_q[2];
  assign io.HEX3 = hex_q[3];
  assign io.HEX4 = hex_q[4];
  assign io.HEX5 = hex_q[5];
  assign io.LEDR = ledr_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a centisecond-level reference model predicts
// every registered display/LED word; a monitor pops and compares each cycle.
module tb_countdown_timer;
  localparam int CPT = 4;
  localparam int DB  = 3;
  localparam int BL  = 8;

  bit         clk;
  logic [1:0] key;
  countdown_timer_if io ();

  countdown_timer #(.CLKS_PER_TICK(CPT), .DEBOUNCE_CLKS(DB), .BLINK_CLKS(BL)) dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .io      (io)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [57:0] exp_q[$];

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_t;
  mstate_t m_st;
  int      m_rem, m_presc, m_blink, m_since, m_run;
  bit      m_phase, m_h1, m_h2, m_stable, m_armed;

  function automatic logic [6:0] seg(int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Display word {HEX5..HEX0, LEDR} derived from remaining centiseconds.
  function automatic logic [57:0] disp(mstate_t st, int r, bit ph);
    int d[6];
    int mins, secs, cs;
    logic [47:0] h;
    logic [9:0]  l;
    mins = r / 6000; secs = (r / 100) % 60; cs = r % 100;
    d[5] = mins / 10; d[4] = mins % 10; d[3] = secs / 10;
    d[2] = secs % 10; d[1] = cs / 10;   d[0] = cs % 10;
    h = '1;
    if (!(st == M_DONE && !ph))
      for (int i = 0; i < 6; i++) h[i*8 +: 8] = {((i == 2) || (i == 4)) ? 1'b0 : 1'b1, seg(d[i])};
    case (st)
      M_RUN:   l = 10'h001;
      M_PAUSE: l = 10'h002;
      M_DONE:  l = ph ? 10'h3FF : 10'h000;
      default: l = 10'h000;
    endcase
    return {h, l};
  endfunction

  always @(posedge clk) begin
    bit s, smp_ok, fell, pre_stable, pre_armed, pr;
    int preset;
    if (!key[0]) begin
      m_st = M_IDLE; m_rem = 0; m_presc = 0; m_blink = 0; m_phase = 0;
      m_h1 = 1; m_h2 = 1; m_stable = 1; m_armed = 0; m_since = 0; m_run = 0;
      exp_q.push_back({48'hFFFF_FFFF_FFFF, 10'h000});
    end else begin
      exp_q.push_back(disp(m_st, m_rem, m_phase));
      s = m_h2; smp_ok = (m_since >= 2);
      m_h2 = m_h1; m_h1 = key[1];
      if (m_since < 2) m_since++;
      pre_stable = m_stable; pre_armed = m_armed; fell = 0;
      if (s != m_stable) begin
        m_run++;
        if (m_run == DB) begin m_stable = s; m_run = 0; fell = !s; end
      end else m_run = 0;
      m_armed = pre_armed | (smp_ok && s && pre_stable);
      pr = fell && pre_armed;
      preset = (int'(io.SW[5:4]) * 10 + ((io.SW[3:0] > 9) ? 9 : int'(io.SW[3:0]))) * 6000;
      case (m_st)
        M_IDLE: begin
          m_rem = preset; m_presc = 0;
          if (pr) begin
            if (preset == 0) begin m_st = M_DONE; m_phase = 1; m_blink = 0; end
            else m_st = M_RUN;
          end
        end
        M_RUN: begin
          if (pr) m_st = M_PAUSE;
          else if (m_presc == CPT - 1) begin
            m_presc = 0; m_rem--;
            if (m_rem == 0) begin m_st = M_DONE; m_phase = 1; m_blink = 0; end
          end else m_presc++;
        end
        M_PAUSE: if (pr) m_st = M_RUN;
        M_DONE: begin
          m_rem = 0;
          if (pr) begin m_st = M_IDLE; m_phase = 0; m_blink = 0; end
          else begin
            m_blink++;
            if (m_blink == BL) begin m_blink = 0; m_phase = !m_phase; end
          end
        end
        default: m_st = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [57:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {io.HEX5, io.HEX4, io.HEX3, io.HEX2, io.HEX1, io.HEX0, io.LEDR};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t got %h want %h", $time, a, e);
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic press_btn(int hold);
    key[1] = 1'b0; step(hold); key[1] = 1'b1; step(DB + 4);
  endtask

  task automatic check(string name, logic [57:0] want);
    logic [57:0] got;
    got = {io.HEX5, io.HEX4, io.HEX3, io.HEX2, io.HEX1, io.HEX0, io.LEDR};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic wait_ledr(string name, logic [9:0] want, int max);
    int n = 0;
    while (io.LEDR !== want && n < max) begin step(1); n++; end
    checks++;
    if (io.LEDR !== want) begin
      errors++;
      $display("FAIL %s timeout got %h want %h", name, io.LEDR, want);
    end
  endtask

  initial begin
    key = 2'b10; io.SW = 6'h0F;
    step(4);
    check("reset_blank", {48'hFFFF_FFFF_FFFF, 10'h000});
    key[0] = 1'b1; step(2);
    check("idle_clamp_0F", {8'hC0, 8'h10, 8'hC0, 8'h40, 8'hC0, 8'hC0, 10'h000});

    io.SW = 6'h01; step(2);
    key[1] = 1'b0;
    wait_ledr("run_entry", 10'h001, 40);
    step(4);
    check("first_tick", {8'hC0, 8'h40, 8'h92, 8'h10, 8'h90, 8'h90, 10'h001});
    step(12); key[1] = 1'b1; step(10);

    for (int off = 0; off < 8; off++) begin
      step(off);
      press_btn(4);
    end

    key[1] = 1'b0; step(2); key[1] = 1'b1; step(10);

    key[0] = 1'b0; step(2);
    check("reset_mid_run", {48'hFFFF_FFFF_FFFF, 10'h000});
    key[0] = 1'b1; step(2);
    check("preset_after_reset", {8'hC0, 8'h79, 8'hC0, 8'h40, 8'hC0, 8'hC0, 10'h000});

    press_btn(4);
    wait_ledr("countdown_done", 10'h3FF, 30000);
    check("done_zero", {8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0, 8'hC0, 10'h3FF});
    press_btn(4);

    io.SW = 6'h00; step(3);
    key[1] = 1'b0;
    wait_ledr("zero_preset_done", 10'h3FF, 40);
    step(8);
    check("blink_off", {48'hFFFF_FFFF_FFFF, 10'h000});
    step(8);
    check("blink_on", {8'hC0, 8'h40, 8'hC0, 8'h40, 8'hC0, 8'hC0, 10'h3FF});
    key[1] = 1'b1; step(10);
    key[0] = 1'b0; step(2); key[0] = 1'b1; step(3);

    io.SW = 6'h02; key = 2'b00; step(3);
    key[0] = 1'b1; step(20);
    check("held_through_reset", {8'hC0, 8'h24, 8'hC0, 8'h40, 8'hC0, 8'hC0, 10'h000});
    key[1] = 1'b1; step(8);
    key[1] = 1'b0;
    wait_ledr("press_after_release", 10'h001, 40);
    key[1] = 1'b1; step(8);

    for (int it = 0; it < 40; it++) begin
      io.SW = 6'($urandom_range(0, 63));
      step($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        key[0] = 1'b0; step($urandom_range(1, 3)); key[0] = 1'b1;
      end else begin
        key[1] = 1'b0; step($urandom_range(1, 6));
        key[1] = 1'b1; step($urandom_range(1, 8));
      end
    end
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter CLKS_PER_TICK, default 500000, CLOCK_50 cycles per 10 ms countdown tick.
REQ-002 Parameter DEBOUNCE_CLKS, default 1000000, cycles KEY[1] must be stable before a level change is accepted.
REQ-003 Parameter BLINK_CLKS, default 12500000, cycles per half-period of the DONE blink (2 Hz).
REQ-004 CLOCK_50  input  1  system clock, all state on rising edge.
REQ-005 KEY[0]  input  1  reset; asynchronous, active-low.
REQ-006 KEY[1]  input  1  start/pause/clear pushbutton, active-low, asynchronous to CLOCK_50.
REQ-007 SW  input  6  preset: SW[5:4] tens of minutes (0-3), SW[3:0] units of minutes, BCD.
REQ-008 HEX0..HEX5  output  8 each  registered active-low 7-seg, bit7 = DP (active-low), bits 6:0 = g..a.
REQ-009 LEDR  output  10  registered status LEDs, active-high.

Function
REQ-010 KEY[1] SHALL pass a 2-FF synchronizer, then a debouncer requiring DEBOUNCE_CLKS consecutive equal samples; a one-cycle press pulse SHALL fire on the debounced high-to-low transition only.
REQ-011 Held button SHALL generate exactly one press pulse; release generates none.
REQ-012 Time SHALL be held as six BCD digits MM:SS.cc: tens-min (0-3), units-min (0-9), tens-sec (0-5), units-sec (0-9), tenths (0-9), hundredths (0-9).
REQ-013 Preset = SW[5:4]:min(SW[3:0],9):00.00; SW[3:0] values 10-15 SHALL clamp to 9.
REQ-014 States: IDLE, RUN, PAUSE, DONE.
REQ-015 IDLE: digits SHALL reload from the preset every cycle; prescaler held at 0.
REQ-016 IDLE + press: if preset nonzero -> RUN; if preset is 00:00.00 -> DONE.
REQ-017 RUN: prescaler increments each cycle; at count CLKS_PER_TICK-1 it wraps to 0 and the digits decrement by one hundredth.
REQ-018 Decrement SHALL borrow digit-wise: hundredths/tenths/units-sec/units-min 0->9 with borrow, tens-sec 0->5 with borrow; tens-min decrements only on borrow.
REQ-019 RUN: the decrement that yields 00:00.00 SHALL move state to DONE on the same edge; digits never wrap below zero.
REQ-020 RUN + press -> PAUSE; press has priority over a coincident tick: decrement suppressed, prescaler holds its value.
REQ-021 PAUSE: digits and prescaler frozen; press -> RUN, prescaler resumes from held value.
REQ-022 DONE: digits stay 00:00.00; blink counter toggles a phase bit every BLINK_CLKS cycles, starting phase on at DONE entry; press -> IDLE.
REQ-023 Display map: HEX5 tens-min, HEX4 units-min, HEX3 tens-sec, HEX2 units-sec, HEX1 tenths, HEX0 hundredths; standard 0-9 active-low patterns (0 = 7'h40).
REQ-024 DP SHALL be lit on HEX4 and HEX2, dark on others.
REQ-025 DONE with phase off: all HEX SHALL be 8'hFF (blank); phase on: normal display.
REQ-026 LEDR: RUN -> 10'h001; PAUSE -> 10'h002; IDLE -> 10'h000; DONE -> 10'h3FF phase on, 10'h000 phase off.
REQ-027 HEX and LEDR SHALL be registered, reflecting state/digits one cycle after they change.

Reset
REQ-028 KEY[0] low SHALL immediately force state IDLE, digits 0, prescaler 0, blink counter and phase 0, debouncer stable level high, synchronizer FFs high.
REQ-029 During reset HEX0..HEX5 SHALL be 8'hFF and LEDR 10'h000.
REQ-030 Reset mid-RUN or mid-DONE SHALL discard progress; after release the first edge loads the preset and the next edge shows it.
REQ-031 A KEY[1] held low through reset release SHALL NOT produce a press pulse until it is released and pressed again.

Verification (CLKS_PER_TICK=4, DEBOUNCE_CLKS=3, BLINK_CLKS=8)
REQ-032 SW=6'h01, press -> RUN; after 4 cycles digits 00:59.99, HEX4=8'h40 (0, DP lit), LEDR=10'h001.
REQ-033 SW=6'h00 in IDLE, press -> DONE directly; LEDR alternates 10'h3FF/10'h000 every 8 cycles, HEX blank in off phase.
REQ-034 Preset 00:00.01 loaded via borrow from 01:00.00 (6000 ticks) -> reaches 00:00.00 and DONE on the same edge, no wrap to 39:59.99.
REQ-035 Press on the exact cycle prescaler=3 -> PAUSE, digits unchanged; press again -> RUN, decrement occurs 1 cycle later.
REQ-036 KEY[1] glitching low for 2 cycles -> no press; held low 20 cycles -> exactly one press.
REQ-037 SW=6'h0F -> IDLE shows 09:00.00; KEY[0] pulsed low mid-RUN -> HEX all 8'hFF, then IDLE with preset.
